// File: rtl/mem_sram_pkg.sv
// mem_sram_pkg
// Shared definitions for the MEM-stage SRAM responder: FSM state encoding,
// data widths and the default per-halfword access time.
package mem_sram_pkg;

    localparam int HALF_W              = 16;
    localparam int WORD_W              = 32;
    localparam int DEFAULT_WAIT_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } state_e;

endpackage

// File: rtl/mem_sram_wait_ctr.sv
// mem_sram_wait_ctr
// 4-bit wait counter that times each halfword access on the SRAM bus.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   clear      load zero on the next edge instead of incrementing
//   last       current count is the terminal count (WAIT_CYCLES-1)
//   next_last  count after the coming edge will be the terminal count
module mem_sram_wait_ctr #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic last,
    output logic next_last
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = clear ? 4'd0 : count_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // next_last lets the owner register outputs that depend on the count
    // in the same cycle the count is reached.
    assign last      = (count_q == LAST_CNT);
    assign next_last = (count_d == LAST_CNT);

endmodule

// File: rtl/mem_sram_responder.sv
// mem_sram_responder
// Services MEM-stage 32-bit loads/stores on a 16-bit asynchronous SRAM using
// two halfword accesses (low half first). ready pulses for one cycle when
// the word is complete; all outputs come straight from flops.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   MemRead, MemWrite         requests, held until ready (write wins if both)
//   in_address, WriteData     byte address (bits [1:0] ignored), store data
//   ReadData, ready           load data, one-cycle completion pulse
//   sram_addr                 halfword address {word index, half select}
//   sram_dq_in/_out/_oe       pad data in, pad data out, pad output enable
//   sram_we_n, sram_oe_n      active-low write strobe and output enable
// Optional feature: define SRAM_LAST_READ_BUF_EN to add a one-entry buffer
// of the last read word so repeated reads complete without SRAM accesses.
module mem_sram_responder
    import mem_sram_pkg::*;
#(
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic [31:0]        in_address,
    input  logic [31:0]        WriteData,
    output logic [31:0]        ReadData,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [15:0]        sram_dq_in,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    state_e state_q, state_d;

    logic [SRAM_AW-2:0] word_q, word_d;
    logic [WORD_W-1:0]  wdata_q, wdata_d;
    logic [WORD_W-1:0]  read_data_q, read_data_d;
    logic               ready_q, ready_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [HALF_W-1:0]  dq_out_q, dq_out_d;
    logic               dq_oe_q, dq_oe_d;
    logic               we_n_q, we_n_d;
    logic               oe_n_q, oe_n_d;

    logic               ctr_clear;
    logic               ctr_last;
    logic               ctr_next_last;
    logic               buf_hit;
    logic [WORD_W-1:0]  buf_rdata;

    logic               unused_addr_bits;
    assign unused_addr_bits = &{1'b0, in_address[31:SRAM_AW+1], in_address[1:0]};

    mem_sram_wait_ctr #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_ctr (
        .clk       (clk),
        .rst       (rst),
        .clear     (ctr_clear),
        .last      (ctr_last),
        .next_last (ctr_next_last)
    );

    // The counter restarts on every state change and stays at zero outside
    // the SRAM access states.
    assign ctr_clear = (state_d != state_q) || (state_q == IDLE) || (state_q == DONE);

    // Next-state and capture logic. While idle the request fields track the
    // inputs, so whatever is present on the accept edge is what gets latched.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;
        case (state_q)
            IDLE: begin
                word_d  = in_address[SRAM_AW:2];
                wdata_d = WriteData;
                if (MemWrite) begin
                    state_d = WR_LO;
                end else if (MemRead && buf_hit) begin
                    state_d     = DONE;
                    read_data_d = buf_rdata;
                end else if (MemRead) begin
                    state_d = RD_LO;
                end
            end
            RD_LO: begin
                if (ctr_last) begin
                    read_data_d[HALF_W-1:0] = sram_dq_in;
                    state_d                 = RD_HI;
                end
            end
            RD_HI: begin
                if (ctr_last) begin
                    read_data_d[WORD_W-1:HALF_W] = sram_dq_in;
                    state_d                      = DONE;
                end
            end
            WR_LO: begin
                if (ctr_last) begin
                    state_d = WR_HI;
                end
            end
            WR_HI: begin
                if (ctr_last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are valid from the
    // first cycle of each state. The write strobe rises in the last cycle of
    // a half to give address/data hold, unless the half is only one cycle.
    always_comb begin
        ready_d     = 1'b0;
        dq_oe_d     = 1'b0;
        we_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        case (state_d)
            RD_LO: begin
                oe_n_d      = 1'b0;
                sram_addr_d = {word_d, 1'b0};
            end
            RD_HI: begin
                oe_n_d      = 1'b0;
                sram_addr_d = {word_d, 1'b1};
            end
            WR_LO: begin
                dq_oe_d     = 1'b1;
                we_n_d      = (WAIT_CYCLES > 1) && ctr_next_last;
                sram_addr_d = {word_d, 1'b0};
                dq_out_d    = wdata_d[HALF_W-1:0];
            end
            WR_HI: begin
                dq_oe_d     = 1'b1;
                we_n_d      = (WAIT_CYCLES > 1) && ctr_next_last;
                sram_addr_d = {word_d, 1'b1};
                dq_out_d    = wdata_d[WORD_W-1:HALF_W];
            end
            DONE:    ready_d = 1'b1;
            default: ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
            ready_q     <= 1'b0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
            ready_q     <= ready_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
        end
    end

`ifdef SRAM_LAST_READ_BUF_EN
    logic               buf_valid_q, buf_valid_d;
    logic [SRAM_AW-2:0] buf_idx_q, buf_idx_d;
    logic [WORD_W-1:0]  buf_data_q, buf_data_d;

    assign buf_hit   = buf_valid_q && (buf_idx_q == in_address[SRAM_AW:2]);
    assign buf_rdata = buf_data_q;

    // A completed SRAM read refills the entry; a completed write to the
    // buffered word keeps it coherent.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_idx_d   = buf_idx_q;
        buf_data_d  = buf_data_q;
        if (state_q == RD_HI && ctr_last) begin
            buf_valid_d = 1'b1;
            buf_idx_d   = word_q;
            buf_data_d  = {sram_dq_in, read_data_q[HALF_W-1:0]};
        end else if (state_q == WR_HI && ctr_last && buf_valid_q && buf_idx_q == word_q) begin
            buf_data_d  = wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid_q <= 1'b0;
            buf_idx_q   <= '0;
            buf_data_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_idx_q   <= buf_idx_d;
            buf_data_q  <= buf_data_d;
        end
    end
`else
    assign buf_hit   = 1'b0;
    assign buf_rdata = '0;
`endif

    assign ReadData    = read_data_q;
    assign ready       = ready_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;
    assign sram_oe_n   = oe_n_q;

endmodule

// File: tb/tb_mem_sram_responder.sv
// tb_mem_sram_responder
// Bench for mem_sram_responder: one instance at the default WAIT_CYCLES=2
// driven from a vector table, and one at WAIT_CYCLES=1 for the back-to-back
// case. Each instance talks to a small SRAM model preloaded with
// 16'h5A00 ^ halfword address. Buffer checks are added when
// SRAM_LAST_READ_BUF_EN is defined.
`timescale 1ns/1ps
module tb_mem_sram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        rd0, wr0, ready0, dqoe0, wen0, oen0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [17:0] saddr0;
    logic [15:0] dqin0, dqout0;

    logic        rd1, wr1, ready1, dqoe1, wen1, oen1;
    logic [31:0] addr1, wdata1, rdata1;
    logic [17:0] saddr1;
    logic [15:0] dqin1, dqout1;

    mem_sram_responder #(.SRAM_AW(18), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .MemRead(rd0), .MemWrite(wr0),
        .in_address(addr0), .WriteData(wdata0), .ReadData(rdata0), .ready(ready0),
        .sram_addr(saddr0), .sram_dq_in(dqin0), .sram_dq_out(dqout0),
        .sram_dq_oe(dqoe0), .sram_we_n(wen0), .sram_oe_n(oen0)
    );

    mem_sram_responder #(.SRAM_AW(18), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .MemRead(rd1), .MemWrite(wr1),
        .in_address(addr1), .WriteData(wdata1), .ReadData(rdata1), .ready(ready1),
        .sram_addr(saddr1), .sram_dq_in(dqin1), .sram_dq_out(dqout1),
        .sram_dq_oe(dqoe1), .sram_we_n(wen1), .sram_oe_n(oen1)
    );

    // SRAM models: preloaded on the first edge, then written on any edge
    // where the strobe and pad driver are both active.
    logic [15:0] mem0 [0:4095];
    logic [15:0] mem1 [0:4095];
    logic        mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 4096; i++) begin
                mem0[i] <= 16'h5A00 ^ 16'(i);
                mem1[i] <= 16'h5A00 ^ 16'(i);
            end
            mem_loaded <= 1'b1;
        end else begin
            if (!wen0 && dqoe0) mem0[saddr0[11:0]] <= dqout0;
            if (!wen1 && dqoe1) mem1[saddr1[11:0]] <= dqout1;
        end
    end

    assign dqin0 = mem0[saddr0[11:0]];
    assign dqin1 = mem1[saddr1[11:0]];

    int conflicts = 0;
    always @(negedge clk) begin
        if (rst && ((!oen0 && dqoe0) || (!oen1 && dqoe1))) conflicts <= conflicts + 1;
    end

    int tests    = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_oe;
        int          exp_we;
        logic [11:0] half_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input string name, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input int exp_lat,
                          input int exp_oe, input int exp_we, input logic [11:0] half_addr);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.exp_data = exp_data; v.exp_lat = exp_lat; v.exp_oe = exp_oe;
        v.exp_we = exp_we; v.half_addr = half_addr;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issues one request on the WAIT_CYCLES=2 instance, scrambles the
    // address/data after the accept edge, and measures latency and strobes.
    task automatic applyStimulus(input vec_t v);
        int lat;
        int oe_low;
        int we_low;
        bit seen;
        @(negedge clk);
        rd0 = v.rd; wr0 = v.wr; addr0 = v.addr; wdata0 = v.wdata;
        @(posedge clk);
        #1;
        addr0 = 32'hFFFF_FFFC; wdata0 = 32'h0BAD_F00D;
        lat = 0; oe_low = 0; we_low = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (!oen0) oe_low++;
            if (!wen0) we_low++;
            if (ready0) seen = 1'b1;
        end
        rd0 = 1'b0; wr0 = 1'b0;
        checkOutput({v.name, " latency"}, lat, v.exp_lat);
        checkOutput({v.name, " oe_n low cycles"}, oe_low, v.exp_oe);
        checkOutput({v.name, " we_n low cycles"}, we_low, v.exp_we);
        if (v.rd && !v.wr) checkOutput({v.name, " ReadData"}, rdata0, v.exp_data);
        if (v.wr) begin
            checkOutput({v.name, " sram low half"}, 32'(mem0[v.half_addr]), 32'(v.wdata[15:0]));
            checkOutput({v.name, " sram high half"}, 32'(mem0[v.half_addr + 12'd1]), 32'(v.wdata[31:16]));
        end
        @(negedge clk);
        checkOutput({v.name, " ready pulse width"}, 32'(ready0), 32'h0);
    endtask

    logic [9:0] rdy_seen;

    initial begin
        rst = 1'b0;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;

        addVec("wr 0x408",       1'b0, 1'b1, 32'h0000_0408, 32'hDEAD_BEEF, 32'h0,         5, 0, 2, 12'h204);
        addVec("rd 0x408",       1'b1, 1'b0, 32'h0000_0408, 32'h0,         32'hDEAD_BEEF, 5, 4, 0, 12'h0);
        addVec("rd+wr 0x10",     1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0,         5, 0, 2, 12'h008);
        addVec("rd 0x10",        1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678, 5, 4, 0, 12'h0);
        addVec("rd 0x100 init",  1'b1, 1'b0, 32'h0000_0100, 32'h0,         32'h5A81_5A80, 5, 4, 0, 12'h0);
        addVec("rd hi-bits 408", 1'b1, 1'b0, 32'hF000_0409, 32'h0,         32'hDEAD_BEEF, 5, 4, 0, 12'h0);

        repeat (3) @(negedge clk);
        checkOutput("reset ReadData",  rdata0,        32'h0);
        checkOutput("reset ready",     32'(ready0),   32'h0);
        checkOutput("reset sram_addr", 32'(saddr0),   32'h0);
        checkOutput("reset dq_out",    32'(dqout0),   32'h0);
        checkOutput("reset dq_oe",     32'(dqoe0),    32'h0);
        checkOutput("reset we_n",      32'(wen0),     32'h1);
        checkOutput("reset oe_n",      32'(oen0),     32'h1);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

        // Reset during the first RD_HI cycle of a read of 0x408.
        @(negedge clk);
        rd0 = 1'b1; addr0 = 32'h0000_0408;
        @(posedge clk);
        repeat (3) @(negedge clk);
        checkOutput("pre-reset oe_n in RD_HI", 32'(oen0), 32'h0);
        rst = 1'b0;
        #1;
        checkOutput("mid-read reset ReadData",  rdata0,      32'h0);
        checkOutput("mid-read reset ready",     32'(ready0), 32'h0);
        checkOutput("mid-read reset sram_addr", 32'(saddr0), 32'h0);
        checkOutput("mid-read reset oe_n",      32'(oen0),   32'h1);
        checkOutput("mid-read reset we_n",      32'(wen0),   32'h1);
        checkOutput("mid-read reset dq_oe",     32'(dqoe0),  32'h0);
        @(negedge clk);
        rst = 1'b1; rd0 = 1'b0;
        begin
            vec_t v;
            v.name = "rd 0x408 after reset"; v.rd = 1'b1; v.wr = 1'b0;
            v.addr = 32'h0000_0408; v.wdata = '0; v.exp_data = 32'hDEAD_BEEF;
            v.exp_lat = 5; v.exp_oe = 4; v.exp_we = 0; v.half_addr = '0;
            applyStimulus(v);
        end

        // WAIT_CYCLES=1: request held through ready, address switched on ready.
        @(negedge clk);
        rd1 = 1'b1; addr1 = 32'h0;
        @(posedge clk);
        rdy_seen = '0;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            rdy_seen[n] = ready1;
            if (n == 3) begin
                checkOutput("w1 first ReadData", rdata1, 32'h5A01_5A00);
                addr1 = 32'h4;
            end
            if (n == 7) begin
                checkOutput("w1 second ReadData", rdata1, 32'h5A03_5A02);
                rd1 = 1'b0;
            end
        end
        checkOutput("w1 ready cycle pattern", 32'(rdy_seen), 32'h0000_0088);

`ifdef SRAM_LAST_READ_BUF_EN
        begin
            vec_t v;
            v.name = "buf rd 0x20 miss"; v.rd = 1'b1; v.wr = 1'b0; v.addr = 32'h20;
            v.wdata = '0; v.exp_data = 32'h5A11_5A10; v.exp_lat = 5; v.exp_oe = 4;
            v.exp_we = 0; v.half_addr = '0;
            applyStimulus(v);
            v.name = "buf rd 0x20 hit"; v.exp_lat = 1; v.exp_oe = 0;
            applyStimulus(v);
            v.name = "buf wr 0x20"; v.rd = 1'b0; v.wr = 1'b1; v.wdata = 32'hA5A5_A5A5;
            v.exp_lat = 5; v.exp_oe = 0; v.exp_we = 2; v.half_addr = 12'h010;
            applyStimulus(v);
            v.name = "buf rd 0x20 after wr"; v.rd = 1'b1; v.wr = 1'b0; v.wdata = '0;
            v.exp_data = 32'hA5A5_A5A5; v.exp_lat = 1; v.exp_oe = 0; v.exp_we = 0;
            applyStimulus(v);
        end
`endif

        checkOutput("oe_n/dq_oe exclusive", 32'(conflicts), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/mem_sram_responder.md
Name: mem_sram_responder

Overview:
- Responder side of the MEM-stage memory interface: accepts the read/write requests the MEM stage issues (address = ALU result, write data = Rm value) and services them on an external 16-bit asynchronous SRAM.
- Every 32-bit word takes two 16-bit SRAM accesses, so the block holds `ready` low until the word completes; the hazard/freeze logic stalls the pipeline on `req && !ready`.
- It replaces the single-cycle behavioural memory in the MEM stage.

Parameters:
- SRAM_AW, 18: SRAM halfword address width. The word index is `in_address[SRAM_AW:2]`, and bit 0 of `sram_addr` selects the half: 0 = low, 1 = high.
- WAIT_CYCLES, 2: cycles each halfword access is held on the SRAM bus. Legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- MemRead  in  1  read request from the MEM stage; held until ready
- MemWrite  in  1  write request from the MEM stage; held until ready
- in_address  in  32  byte address (ALU result); bits [1:0] are ignored
- WriteData  in  32  store data
- ReadData  out  32  load data; valid while ready=1 for a read
- ready  out  1  one-cycle completion pulse
- sram_addr  out  SRAM_AW  SRAM halfword address
- sram_dq_in  in  16  SRAM data from the pad
- sram_dq_out  out  16  SRAM data to the pad
- sram_dq_oe  out  1  pad output enable; high only during write states
- sram_we_n  out  1  SRAM write strobe, active-low
- sram_oe_n  out  1  SRAM output enable, active-low

Behaviour:
- Reset (async, rst=0) forces:
  - state=IDLE, wait counter=0, ReadData=0, ready=0, sram_addr=0, sram_dq_out=0
  - sram_dq_oe=0, sram_we_n=1, sram_oe_n=1
- Reset mid-transaction abandons the access. No partial word is reported, and a half-written SRAM word is acceptable.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE. All outputs are registered.
- IDLE:
  - MemWrite=1 -> WR_LO. MemWrite wins if both requests are high; that case is illegal, but the block must stay well-defined.
  - else MemRead=1 -> RD_LO.
  - Address, data and direction are latched on the accept edge. Later input changes are ignored until DONE.
- RD_LO / RD_HI:
  - sram_oe_n=0, sram_addr={word,0} / {word,1}.
  - Counter runs 0..WAIT_CYCLES-1. On the last count, sram_dq_in is captured into ReadData[15:0] / [31:16], then the state advances to RD_HI / DONE.
- WR_LO / WR_HI:
  - sram_dq_oe=1, sram_dq_out=WriteData[15:0] / [31:16].
  - sram_we_n=0 for all cycles except the last, where it returns to 1 to give address/data hold. With WAIT_CYCLES=1, sram_we_n=0 for that one cycle.
- DONE: ready=1 for exactly one cycle -> IDLE. ReadData holds its value until the next read completes.
- Latency: ready rises on cycle 2*WAIT_CYCLES+1 after the accept edge (5 cycles at default).
- A request still high in the IDLE cycle after DONE is treated as a new request. The pipeline must drop or replace the request once ready is seen.
- The wait counter is 4 bits and clears on every state change. No wrap occurs inside the legal range.
- sram_dq_oe and sram_oe_n are never both active.

Optional Feature:
- Macro: SRAM_LAST_READ_BUF_EN.
- With the macro defined:
  - A one-entry buffer holds {valid, word index, data}.
  - A read in IDLE that hits the buffer goes directly to DONE, so ready arrives on cycle 1 with the buffered data.
  - A miss fills the buffer on completion.
  - A write to the buffered index updates the buffer data on completion.
  - Reset clears valid.
- Without the macro: no buffer; every read takes the full SRAM latency.

Decomposition:
- Package mem_sram_pkg holds:
  - state enum (IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE)
  - constants HALF_W=16, WORD_W=32
  - default WAIT_CYCLES
- Sub-module: mem_sram_wait_ctr, a parameterised wait counter with clear and terminal-count output.
- The FSM and datapath stay in the top module.

Test Plan:
- Reset mid-RD_HI (rst=0 for 1 cycle) -> all outputs return to reset values immediately; the next read of any address completes normally.
- Write 0xDEADBEEF to address 0x0000_0408 -> two SRAM writes: half address 0x204 gets 0xBEEF, then 0x205 gets 0xDEAD; sram_we_n is low for 1 cycle per half; ready pulses on cycle 5.
- Read back 0x0000_0408 -> sram_oe_n=0 across both halves; ready on cycle 5 with ReadData=0xDEADBEEF.
- MemRead=MemWrite=1 at address 0x10 with data 0x12345678 -> a write occurs (SRAM 0x8=0x5678, 0x9=0x1234) and no read strobe is issued.
- WAIT_CYCLES=1: back-to-back reads of 0x0 and 0x4 with the request held through ready -> ready at cycles 3 and 7, no glitch pulses. In this case the second request is accepted in the IDLE cycle (cycle 4) and completes at cycle 7.
- With SRAM_LAST_READ_BUF_EN: read 0x20 (ready cycle 5), read 0x20 again (ready cycle 1, no SRAM strobe), write 0x20 with 0xA5A5A5A5, then read -> 0xA5A5A5A5 from the buffer.
